key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_pkg.sv | 16 +
 rtl/key_event_ctrl_rr_arbiter.sv | 31 +++
 rtl/key_event_ctrl.sv | 127 ++++++++++++
 tb/tb_key_event_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and types for the key event controller.
package key_pkg;

  localparam int NUM_KEYS   = 4;
  localparam int FIFO_DEPTH = 4;

  // Key index width, kept at least one bit wide for a single-key build.
  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  // Occupancy width must hold the value FIFO_DEPTH itself.
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef logic [KEY_W-1:0] key_id_t;
  typedef logic [CNT_W-1:0] evt_cnt_t;

endpackage

// File: rtl/key_event_ctrl_rr_arbiter.sv
// Round-robin grant: picks the first requesting key above last_grant, wrapping.
module rr_arbiter #(
  parameter  int NUM_KEYS = 4,
  localparam int IW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic [NUM_KEYS-1:0] req,
  input  logic [IW-1:0]       last_grant,
  output logic [NUM_KEYS-1:0] grant,
  output logic [IW-1:0]       grant_idx,
  output logic                grant_vld
);

  int idx;

  // Walk the keys starting one above the previous winner; first request found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_KEYS; off++) begin
      idx = (int'(last_grant) + off) % NUM_KEYS;
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Collects per-key press pulses into pending bits, arbitrates them round-robin
// and queues the winning key indices in a first-word fall-through FIFO.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter  int NUM_KEYS   = key_pkg::NUM_KEYS,
  parameter  int FIFO_DEPTH = key_pkg::FIFO_DEPTH,
  localparam int IW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1,
  localparam int PW         = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_pulse,
  input  logic [NUM_KEYS-1:0] key_en,
  output logic                evt_valid,
  output logic [IW-1:0]       evt_key,
  input  logic                evt_ready,
  output logic [CW-1:0]       evt_count,
  output logic                drop_sticky,
  input  logic                clr_drop
);

  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pending_nx;
  logic [NUM_KEYS-1:0] req;
  logic [NUM_KEYS-1:0] grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  logic [IW-1:0]       last_grant;

  logic [IW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       rd_ptr_nx;
  logic [CW-1:0]       count_nx;
  logic [IW-1:0]       head_nx;

  logic                push;
  logic                pop;
  logic                push_ok;
  logic                drop_set;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop     = evt_valid & evt_ready;
  assign push_ok = (evt_count < CW'(FIFO_DEPTH)) | pop;

  // Masked keys never compete; they are flushed below instead.
  assign req  = pending & key_en & {NUM_KEYS{push_ok}};
  assign push = grant_vld;

  rr_arbiter #(
    .NUM_KEYS (NUM_KEYS)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  // Next pending bits; a pulse on a waiting, ungranted key is lost and flagged.
  always_comb begin
    pending_nx = pending;
    drop_set   = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!key_en[i]) begin
        pending_nx[i] = 1'b0;
      end else if (grant[i]) begin
        pending_nx[i] = key_pulse[i];
      end else begin
        if (pending[i] && key_pulse[i]) drop_set = 1'b1;
        pending_nx[i] = pending[i] | key_pulse[i];
      end
    end
  end

  assign rd_ptr_nx = pop ? rd_ptr + PW'(1) : rd_ptr;

  // Occupancy after this edge.
  always_comb begin
    case ({push, pop})
      2'b10:   count_nx = evt_count + CW'(1);
      2'b01:   count_nx = evt_count - CW'(1);
      default: count_nx = evt_count;
    endcase
  end

  // Next head entry; the slot being written becomes head only when the queue drains to it.
  always_comb begin
    if (count_nx == '0)                      head_nx = '0;
    else if (push && (rd_ptr_nx == wr_ptr))  head_nx = grant_idx;
    else                                     head_nx = mem[rd_ptr_nx];
  end

  // Queue storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant_idx;
  end

  // Control state: pending bits, arbitration history, pointers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      last_grant  <= IW'(NUM_KEYS - 1);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      evt_count   <= '0;
      evt_valid   <= 1'b0;
      evt_key     <= '0;
      drop_sticky <= 1'b0;
    end else begin
      pending   <= pending_nx;
      rd_ptr    <= rd_ptr_nx;
      evt_count <= count_nx;
      evt_valid <= (count_nx != '0);
      evt_key   <= head_nx;
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        last_grant <= grant_idx;
      end
      if (drop_set)      drop_sticky <= 1'b1;
      else if (clr_drop) drop_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: a vector table plus a reset corner sequence.
module tb_key_event_ctrl;
  import key_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NUM_KEYS-1:0] key_pulse;
  logic [NUM_KEYS-1:0] key_en;
  logic                evt_valid;
  key_id_t             evt_key;
  logic                evt_ready;
  evt_cnt_t            evt_count;
  logic                drop_sticky;
  logic                clr_drop;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] pulse;
    logic [3:0] en;
    logic       ready;
    logic       clr;
    logic       ev;
    int         ek;
    int         ec;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  key_event_ctrl #(
    .NUM_KEYS   (NUM_KEYS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_pulse   (key_pulse),
    .key_en      (key_en),
    .evt_valid   (evt_valid),
    .evt_key     (evt_key),
    .evt_ready   (evt_ready),
    .evt_count   (evt_count),
    .drop_sticky (drop_sticky),
    .clr_drop    (clr_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input int ek, input int ec, input logic ed);
    chk({tag, ".valid"}, int'(evt_valid), int'(ev));
    chk({tag, ".count"}, int'(evt_count), ec);
    chk({tag, ".drop"},  int'(drop_sticky), int'(ed));
    if (ev) chk({tag, ".key"}, int'(evt_key), ek);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // pulse, en, ready, clr -> valid, key, count, drop
    // four simultaneous presses after reset queue in order 0,1,2,3
    vecs.push_back('{4'b1111, 4'hF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 1, 3, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 2, 2, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 3, 1, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    // single press on key 2: visible two edges later, then popped
    vecs.push_back('{4'b0100, 4'hF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 2, 1, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    // fill from last_grant=2: order 3,0,1,2; re-press in grant cycle is no drop
    vecs.push_back('{4'b1111, 4'hF, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 3, 1, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 3, 2, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0});
    vecs.push_back('{4'b1111, 4'hF, 1'b0, 1'b0, 1'b1, 3, 4, 1'b0});
    // full and all pending: another key 1 press is dropped, then cleared
    vecs.push_back('{4'b0010, 4'hF, 1'b0, 1'b0, 1'b1, 3, 4, 1'b1});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b1, 1'b1, 3, 4, 1'b0});
    // clear in the same cycle as a new drop: set wins
    vecs.push_back('{4'b0001, 4'hF, 1'b0, 1'b1, 1'b1, 3, 4, 1'b1});
    vecs.push_back('{4'b0000, 4'hF, 1'b0, 1'b1, 1'b1, 3, 4, 1'b0});
    // full with ready held: push+pop each cycle, count stays 4, rotation 3,0,1,2
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 0, 4, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 1, 4, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 2, 4, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 3, 4, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 0, 3, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 1, 2, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0});
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    // ready while empty does nothing
    vecs.push_back('{4'b0000, 4'hF, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0});
    // masked press on key 3, then key 1 pending flushed by disabling it
    vecs.push_back('{4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0010, 4'hF,    1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'b1101, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 0, 0, 1'b0});
    vecs.push_back('{4'b0000, 4'hF,    1'b0, 1'b0, 1'b0, 0, 0, 1'b0});

    reset_n   = 1'b0;
    key_pulse = '0;
    key_en    = '1;
    evt_ready = 1'b0;
    clr_drop  = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 0, 0, 1'b0);
    chk("reset.key", int'(evt_key), 0);
    reset_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      key_pulse = vecs[r].pulse;
      key_en    = vecs[r].en;
      evt_ready = vecs[r].ready;
      clr_drop  = vecs[r].clr;
      tick();
      chk_out($sformatf("row%0d", r), vecs[r].ev, vecs[r].ek, vecs[r].ec, vecs[r].ed);
    end

    // Reset with three queued events and key 2 still pending.
    key_pulse = 4'b1111; key_en = 4'hF; evt_ready = 1'b0; clr_drop = 1'b0;
    tick();
    key_pulse = '0;
    tick();
    tick();
    tick();
    chk_out("prerst", 1'b1, 3, 3, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_out("inrst", 1'b0, 0, 0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_out("postrst0", 1'b0, 0, 0, 1'b0);
    tick();
    chk_out("postrst1", 1'b0, 0, 0, 1'b0);
    key_pulse = 4'b1111;
    tick();
    key_pulse = '0;
    tick();
    chk_out("firstgrant", 1'b1, 0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
